// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter for a single BRAM port (PE controller vs. external host).
// One access per cycle, combinational grant, one-cycle read-valid tag per access.
// A bounded-burst counter hands the port to the waiting side after MAX_BURST
// back-to-back grants to the current owner.
module bram_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pe_run,
  input  logic                  pe_req,
  input  logic                  pe_we,
  input  logic [ADDR_WIDTH-1:0] pe_addr,
  input  logic [DATA_WIDTH-1:0] pe_wdata,
  output logic                  pe_gnt,
  output logic                  pe_rvalid,
  output logic [DATA_WIDTH-1:0] pe_rdata,
  input  logic                  ext_req,
  input  logic                  ext_we,
  input  logic [ADDR_WIDTH-1:0] ext_addr,
  input  logic [DATA_WIDTH-1:0] ext_wdata,
  output logic                  ext_gnt,
  output logic                  ext_rvalid,
  output logic [DATA_WIDTH-1:0] ext_rdata,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_wdata,
  input  logic [DATA_WIDTH-1:0] bram_rdata,
  output logic [1:0]            owner
);

  localparam int unsigned    CntW   = $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_BURST);

  localparam logic [1:0] OwnIdle = 2'd0;
  localparam logic [1:0] OwnPe   = 2'd1;
  localparam logic [1:0] OwnExt  = 2'd2;

  logic [1:0]      owner_q, owner_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      rd_tag_q, rd_tag_d;
  logic            pe_win, ext_win;
  logic            other_req;

  // Grant decision: owner keeps the port until the other side has waited MAX_BURST grants.
  always_comb begin
    pe_win  = 1'b0;
    ext_win = 1'b0;
    if (!rst) begin
      case (owner_q)
        OwnPe: begin
          if (pe_req && (!ext_req || cnt_q < CntMax)) pe_win = 1'b1;
          else if (ext_req)                           ext_win = 1'b1;
        end
        OwnExt: begin
          if (ext_req && (!pe_req || cnt_q < CntMax)) ext_win = 1'b1;
          else if (pe_req)                            pe_win  = 1'b1;
        end
        default: begin
          // From idle, pe_run breaks the tie.
          if (pe_req && (!ext_req || pe_run)) pe_win  = 1'b1;
          else if (ext_req)                   ext_win = 1'b1;
        end
      endcase
    end
  end

  // Ownership / burst-counter next state and per-access read tags.
  always_comb begin
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    other_req = pe_win ? ext_req : pe_req;
    if (!pe_win && !ext_win) begin
      owner_d = OwnIdle;
      cnt_d   = '0;
    end else if ((pe_win && owner_q == OwnPe) || (ext_win && owner_q == OwnExt)) begin
      if (other_req) cnt_d = (cnt_q == CntMax) ? CntMax : cnt_q + CntW'(1);
      else           cnt_d = CntW'(1);
    end else begin
      owner_d = pe_win ? OwnPe : OwnExt;
      cnt_d   = CntW'(1);
    end
    rd_tag_d = {pe_win & ~pe_we, ext_win & ~ext_we};
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q  <= OwnIdle;
      cnt_q    <= '0;
      rd_tag_q <= '0;
    end else begin
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      rd_tag_q <= rd_tag_d;
    end
  end

  // BRAM command mux from the winner; all zero when nobody is granted.
  always_comb begin
    bram_we    = 1'b0;
    bram_addr  = '0;
    bram_wdata = '0;
    if (pe_win) begin
      bram_we    = pe_we;
      bram_addr  = pe_addr;
      bram_wdata = pe_wdata;
    end else if (ext_win) begin
      bram_we    = ext_we;
      bram_addr  = ext_addr;
      bram_wdata = ext_wdata;
    end
  end

  assign pe_gnt  = pe_win;
  assign ext_gnt = ext_win;
  assign bram_en = pe_win | ext_win;
  assign owner   = owner_q;

  // Gating with rst drops a read granted just before reset in the reset cycle itself.
  assign pe_rvalid  = rd_tag_q[1] & ~rst;
  assign ext_rvalid = rd_tag_q[0] & ~rst;
  assign pe_rdata   = bram_rdata;
  assign ext_rdata  = bram_rdata;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter: grant/owner checks inline, read data
// checked by a scoreboard monitor that pops expected values on each rvalid.
module tb_bram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pe_run;
  logic        pe_req, pe_we, ext_req, ext_we;
  logic [9:0]  pe_addr, ext_addr;
  logic [31:0] pe_wdata, ext_wdata;
  logic        pe_gnt, ext_gnt, pe_rvalid, ext_rvalid;
  logic [31:0] pe_rdata, ext_rdata;
  logic        bram_en, bram_we;
  logic [9:0]  bram_addr;
  logic [31:0] bram_wdata, bram_rdata;
  logic [1:0]  owner;

  logic [31:0] mem [0:1023];
  logic [31:0] pe_q[$];
  logic [31:0] ext_q[$];
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  bram_port_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .pe_run(pe_run),
    .pe_req(pe_req), .pe_we(pe_we), .pe_addr(pe_addr), .pe_wdata(pe_wdata),
    .pe_gnt(pe_gnt), .pe_rvalid(pe_rvalid), .pe_rdata(pe_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata), .owner(owner)
  );

  // Behavioural BRAM, preloaded while in reset.
  always @(posedge clk) begin
    if (rst) begin
      mem[10'h005] <= 32'hDEADBEEF;
      mem[10'h010] <= 32'hA5A50010;
    end else if (bram_en) begin
      if (bram_we) mem[bram_addr] <= bram_wdata;
      else         bram_rdata     <= mem[bram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (pe_rvalid) begin
      if (pe_q.size() == 0) chk1("pe_rvalid_unexpected", pe_rvalid, 1'b0);
      else                  chk("pe_rdata", pe_rdata, pe_q.pop_front());
    end
    if (ext_rvalid) begin
      if (ext_q.size() == 0) chk1("ext_rvalid_unexpected", ext_rvalid, 1'b0);
      else                   chk("ext_rdata", ext_rdata, ext_q.pop_front());
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       exp_pe;
    logic [1:0] exp_own;
    rst = 1'b1; pe_run = 1'b1;
    pe_req = 1'b1;  pe_we = 1'b0;  pe_addr = 10'h010;  pe_wdata = '0;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 10'h005; ext_wdata = '0;

    // Reset with both requesting.
    @(negedge clk);
    chk1("rst_pe_gnt", pe_gnt, 1'b0);
    chk1("rst_ext_gnt", ext_gnt, 1'b0);
    chk1("rst_bram_en", bram_en, 1'b0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk1("rst_pe_rvalid", pe_rvalid, 1'b0);
    chk1("rst_ext_rvalid", ext_rvalid, 1'b0);
    next_cycle();
    rst = 1'b0;

    // Fairness: PE x4, EXT x4, PE x4 with no gaps; first grant after reset is PE.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      exp_pe  = ((i / 4) % 2) == 0;
      exp_own = (i == 0) ? 2'd0 : ((((i - 1) / 4) % 2) == 0 ? 2'd1 : 2'd2);
      chk1("fair_pe_gnt", pe_gnt, exp_pe);
      chk1("fair_ext_gnt", ext_gnt, !exp_pe);
      chk1("fair_bram_en", bram_en, 1'b1);
      chk("fair_owner", 32'(owner), 32'(exp_own));
      if (exp_pe) pe_q.push_back(32'hA5A50010);
      else        ext_q.push_back(32'hDEADBEEF);
      next_cycle();
    end

    // Idle cycle: nothing granted, owner still PE from last grant.
    pe_req = 1'b0; ext_req = 1'b0;
    @(negedge clk);
    chk1("idle_bram_en", bram_en, 1'b0);
    chk("idle_owner_pe", 32'(owner), 32'd1);
    next_cycle();

    // Single requester: ext reads 0x005.
    ext_req = 1'b1;
    @(negedge clk);
    chk("single_owner_idle", 32'(owner), 32'd0);
    chk1("single_ext_gnt", ext_gnt, 1'b1);
    chk1("single_pe_gnt", pe_gnt, 1'b0);
    chk("single_bram_addr", 32'(bram_addr), 32'h005);
    ext_q.push_back(32'hDEADBEEF);
    next_cycle();
    ext_req = 1'b0;
    @(negedge clk);
    chk1("single_ext_rvalid", ext_rvalid, 1'b1);
    chk1("single_pe_rvalid", pe_rvalid, 1'b0);
    next_cycle();

    // PE read granted, then reset next cycle: that read is dropped.
    pe_req = 1'b1;
    @(negedge clk);
    chk1("drop_pe_gnt", pe_gnt, 1'b1);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk1("drop_pe_rvalid", pe_rvalid, 1'b0);
    chk1("drop_pe_gnt_rst", pe_gnt, 1'b0);
    chk1("drop_bram_en_rst", bram_en, 1'b0);
    next_cycle();

    // Tie from idle with pe_run=0: ext wins.
    rst = 1'b0; pe_run = 1'b0; ext_req = 1'b1;
    @(negedge clk);
    chk1("tie_ext_gnt", ext_gnt, 1'b1);
    chk1("tie_pe_gnt", pe_gnt, 1'b0);
    ext_q.push_back(32'hDEADBEEF);
    next_cycle();

    // PE writes 0x12345678 to 0x3FF (ext not requesting, owner EXT).
    ext_req = 1'b0; pe_we = 1'b1; pe_addr = 10'h3FF; pe_wdata = 32'h12345678;
    @(negedge clk);
    chk1("wr_pe_gnt", pe_gnt, 1'b1);
    chk1("wr_bram_we", bram_we, 1'b1);
    chk("wr_bram_addr", 32'(bram_addr), 32'h3FF);
    chk("wr_bram_wdata", bram_wdata, 32'h12345678);
    next_cycle();

    // Handoff: PE drops req, ext reads 0x3FF in the same cycle.
    pe_req = 1'b0; pe_we = 1'b0;
    ext_req = 1'b1; ext_addr = 10'h3FF;
    @(negedge clk);
    chk1("hand_ext_gnt", ext_gnt, 1'b1);
    chk1("hand_bram_we", bram_we, 1'b0);
    chk("hand_owner_pe", 32'(owner), 32'd1);
    chk1("hand_no_wr_rvalid", pe_rvalid, 1'b0);
    ext_q.push_back(32'h12345678);
    next_cycle();

    ext_req = 1'b0;
    @(negedge clk);
    chk1("end_ext_rvalid", ext_rvalid, 1'b1);
    chk1("end_bram_en", bram_en, 1'b0);
    chk("end_bram_addr", 32'(bram_addr), 32'd0);
    chk("end_bram_wdata", bram_wdata, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("pe_q_drained", 32'(pe_q.size()), 32'd0);
    chk("ext_q_drained", 32'(ext_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
